// File: rtl/alarm_pkg.sv
// Shared types for the alarm sequencer: state encoding and output decode.
package alarm_pkg;

    // 3-bit state encoding, also driven onto the debug/LED state port.
    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    // Status flags derived purely from a state value.
    typedef struct packed {
        logic alarm;
        logic armed;
        logic pending;
    } status_t;

    // Map a state to its siren / armed / delay-running flags.
    function automatic status_t decode_status(state_e s);
        status_t st;
        st.alarm   = (s == ST_ALARM);
        st.armed   = (s == ST_ARMED)  || (s == ST_ENTRY);
        st.pending = (s == ST_ARMING) || (s == ST_ENTRY);
        return st;
    endfunction

endpackage

// File: rtl/alarm_sequencer_in_sync.sv
// Two-flop synchroniser for one asynchronous board input, with a rising-edge
// pulse taken from the synchronised level and one extra history flop.
module in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    // Synchronise the raw input and keep one cycle of history for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~s2_d;

endmodule

// File: rtl/alarm_sequencer.sv
// Door/key/sensor/panic alarm controller. Inputs are synchronised, the key is
// edge-detected, and a single shared counter times the exit delay, entry delay
// and alarm hold. All outputs are registered decodes of the next state so they
// move in the same cycle as the state register.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXIT_DLY   = 4,
    parameter int ENTRY_DLY  = 6,
    parameter int ALARM_HOLD = 8,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       D,
    input  logic       K,
    input  logic       S,
    input  logic       B,
    output logic       A,
    output logic       armed,
    output logic       pending,
    output logic [2:0] state
);

    // Each timed state loads DLY-1 and expires when the counter reads zero,
    // so it lasts exactly DLY cycles.
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(ALARM_HOLD - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic       d_s;
    logic       s_s;
    logic       b_s;
    logic       kr;
    logic       k_sync_unused;
    logic [2:0] rise_unused;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    status_t          nxt_status;

    in_sync u_sync_d (.clk(clk), .rst_n(rst_n), .din(D), .dout(d_s),           .rise(rise_unused[0]));
    in_sync u_sync_k (.clk(clk), .rst_n(rst_n), .din(K), .dout(k_sync_unused), .rise(kr));
    in_sync u_sync_s (.clk(clk), .rst_n(rst_n), .din(S), .dout(s_s),           .rise(rise_unused[1]));
    in_sync u_sync_b (.clk(clk), .rst_n(rst_n), .din(B), .dout(b_s),           .rise(rise_unused[2]));

    // Next-state and counter: priority within each state is panic, intrusion,
    // key, then door/expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_DISARMED: begin
                if (b_s) begin
                    state_d = ST_ALARM;
                    cnt_d   = HOLD_LD;
                end else if (kr) begin
                    state_d = ST_ARMING;
                    cnt_d   = EXIT_LD;
                end
            end
            ST_ARMING: begin
                // Door and sensor are deliberately ignored during exit delay.
                if (b_s) begin
                    state_d = ST_ALARM;
                    cnt_d   = HOLD_LD;
                end else if (kr) begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ARMED;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_ARMED: begin
                if (b_s || s_s) begin
                    state_d = ST_ALARM;
                    cnt_d   = HOLD_LD;
                end else if (kr) begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end else if (d_s) begin
                    state_d = ST_ENTRY;
                    cnt_d   = ENTRY_LD;
                end
            end
            ST_ENTRY: begin
                if (b_s || s_s) begin
                    state_d = ST_ALARM;
                    cnt_d   = HOLD_LD;
                end else if (kr) begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ALARM;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_ALARM: begin
                // Panic held while already alarming does not restart the hold;
                // without auto-rearm the counter parks at zero.
                if (kr) begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (AUTO_REARM) begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_DISARMED;
                cnt_d   = '0;
            end
        endcase
    end

    assign nxt_status = decode_status(state_d);

    // State, counter and registered output decode; reset clears the siren at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DISARMED;
            cnt_q   <= '0;
            A       <= 1'b0;
            armed   <= 1'b0;
            pending <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            A       <= nxt_status.alarm;
            armed   <= nxt_status.armed;
            pending <= nxt_status.pending;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: two instances share stimulus, one with auto-rearm
// off and one with it on. Each row drives inputs at the falling edge, pushes the
// expected {A, armed, pending, state} of both instances, and pops/compares after
// the next rising edge.
module tb_alarm_sequencer;

    localparam logic [2:0] S_DIS = 3'd0;
    localparam logic [2:0] S_ARM = 3'd1;
    localparam logic [2:0] S_ARD = 3'd2;
    localparam logic [2:0] S_ENT = 3'd3;
    localparam logic [2:0] S_ALM = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d = 1'b0;
    logic k = 1'b0;
    logic s = 1'b0;
    logic b = 1'b0;

    logic       a0, armed0, pending0;
    logic [2:0] st0;
    logic       a1, armed1, pending1;
    logic [2:0] st1;

    typedef struct {
        logic       d;
        logic       k;
        logic       s;
        logic       b;
        logic [2:0] e0;
        logic [2:0] e1;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    // clock
    always #5 clk = ~clk;

    alarm_sequencer #(
        .CNT_W(8), .EXIT_DLY(4), .ENTRY_DLY(6), .ALARM_HOLD(8), .AUTO_REARM(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .D(d), .K(k), .S(s), .B(b),
        .A(a0), .armed(armed0), .pending(pending0), .state(st0)
    );

    alarm_sequencer #(
        .CNT_W(8), .EXIT_DLY(4), .ENTRY_DLY(6), .ALARM_HOLD(8), .AUTO_REARM(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .D(d), .K(k), .S(s), .B(b),
        .A(a1), .armed(armed1), .pending(pending1), .state(st1)
    );

    // Expected {A, armed, pending, state} for a given state.
    function automatic logic [5:0] exp_bits(input logic [2:0] st);
        logic ea, ear, ep;
        ea  = (st == S_ALM);
        ear = (st == S_ARD) || (st == S_ENT);
        ep  = (st == S_ARM) || (st == S_ENT);
        return {ea, ear, ep, st};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got A=%b armed=%b pending=%b state=%0d, want A=%b armed=%b pending=%b state=%0d",
                     name, act[5], act[4], act[3], act[2:0], expv[5], expv[4], expv[3], expv[2:0]);
        end
    endtask

    task automatic add(input logic dd, input logic kk, input logic ss, input logic bb,
                       input logic [2:0] e0, input logic [2:0] e1, input int n);
        vec_t v;
        v.d = dd; v.k = kk; v.s = ss; v.b = bb; v.e0 = e0; v.e1 = e1;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive one row, advance one clock, compare against the scoreboard head.
    task automatic step(input logic dd, input logic kk, input logic ss, input logic bb,
                        input logic [2:0] e0, input logic [2:0] e1, input string tag);
        logic [11:0] e;
        d = dd; k = kk; s = ss; b = bb;
        exp_q.push_back({exp_bits(e0), exp_bits(e1)});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " dut0"}, {a0, armed0, pending0, st0}, e[11:6]);
            check({tag, " dut1"}, {a1, armed1, pending1, st1}, e[5:0]);
        end
    endtask

    initial begin
        // idle after reset
        add(0,0,0,0, S_DIS,S_DIS, 20);
        // key pulse arms; door wiggle during exit delay is ignored
        add(0,1,0,0, S_DIS,S_DIS, 1);  add(0,0,0,0, S_DIS,S_DIS, 1);
        add(1,0,0,0, S_ARM,S_ARM, 2);  add(0,0,0,0, S_ARM,S_ARM, 2);
        add(0,0,0,0, S_ARD,S_ARD, 2);
        // door opens: six cycles of entry delay then alarm; key disarms
        add(1,0,0,0, S_ARD,S_ARD, 1);  add(0,0,0,0, S_ARD,S_ARD, 1);
        add(0,0,0,0, S_ENT,S_ENT, 6);  add(0,0,0,0, S_ALM,S_ALM, 1);
        add(0,1,0,0, S_ALM,S_ALM, 1);  add(0,0,0,0, S_ALM,S_ALM, 1);
        add(0,0,0,0, S_DIS,S_DIS, 1);
        // re-arm, open door, key in third entry cycle cancels before alarm
        add(0,1,0,0, S_DIS,S_DIS, 1);  add(0,0,0,0, S_DIS,S_DIS, 1);
        add(0,0,0,0, S_ARM,S_ARM, 4);  add(1,0,0,0, S_ARD,S_ARD, 1);
        add(0,0,0,0, S_ARD,S_ARD, 1);  add(0,0,0,0, S_ENT,S_ENT, 2);
        add(0,1,0,0, S_ENT,S_ENT, 1);  add(0,0,0,0, S_ENT,S_ENT, 1);
        add(0,0,0,0, S_DIS,S_DIS, 3);
        // armed, sensor trips: alarm two edges later; key disarms
        add(0,1,0,0, S_DIS,S_DIS, 1);  add(0,0,0,0, S_DIS,S_DIS, 1);
        add(0,0,0,0, S_ARM,S_ARM, 4);  add(0,0,0,0, S_ARD,S_ARD, 1);
        add(0,0,1,0, S_ARD,S_ARD, 1);  add(0,0,0,0, S_ARD,S_ARD, 1);
        add(0,0,0,0, S_ALM,S_ALM, 1);  add(0,1,0,0, S_ALM,S_ALM, 1);
        add(0,0,0,0, S_ALM,S_ALM, 1);  add(0,0,0,0, S_DIS,S_DIS, 1);
        // armed, door and key in the same cycle: key wins
        add(0,1,0,0, S_DIS,S_DIS, 1);  add(0,0,0,0, S_DIS,S_DIS, 1);
        add(0,0,0,0, S_ARM,S_ARM, 4);  add(0,0,0,0, S_ARD,S_ARD, 1);
        add(1,1,0,0, S_ARD,S_ARD, 1);  add(0,0,0,0, S_ARD,S_ARD, 1);
        add(0,0,0,0, S_DIS,S_DIS, 3);
        // panic+key+sensor together from disarmed: panic wins. Panic held
        // does not restart hold; rearm instance sees door on arrival in ARMED.
        add(0,1,1,1, S_DIS,S_DIS, 2);  add(0,0,0,1, S_ALM,S_ALM, 2);
        add(0,0,0,0, S_ALM,S_ALM, 4);  add(1,0,0,0, S_ALM,S_ALM, 2);
        add(0,0,0,0, S_ALM,S_ARD, 1);  add(0,0,0,0, S_ALM,S_ENT, 6);
        add(0,0,0,0, S_ALM,S_ALM, 3);  add(0,1,0,0, S_ALM,S_ALM, 1);
        add(0,0,0,0, S_ALM,S_ALM, 1);  add(0,0,0,0, S_DIS,S_DIS, 3);

        // reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dut0", {a0, armed0, pending0, st0}, exp_bits(S_DIS));
        check("reset dut1", {a1, armed1, pending1, st1}, exp_bits(S_DIS));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].k, vecs[i].s, vecs[i].b, vecs[i].e0, vecs[i].e1,
                 $sformatf("row%0d", i));
        end

        // panic into alarm, then reset for one cycle with key held high
        step(0,0,0,1, S_DIS,S_DIS, "rst_seq pre0");
        step(0,0,0,0, S_DIS,S_DIS, "rst_seq pre1");
        step(0,0,0,0, S_ALM,S_ALM, "rst_seq pre2");
        step(0,0,0,0, S_ALM,S_ALM, "rst_seq pre3");
        k = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_async dut0", {a0, armed0, pending0, st0}, exp_bits(S_DIS));
        check("rst_async dut1", {a1, armed1, pending1, st1}, exp_bits(S_DIS));
        @(negedge clk);
        rst_n = 1'b1;
        step(0,1,0,0, S_DIS,S_DIS, "rst_seq post0");
        step(0,1,0,0, S_DIS,S_DIS, "rst_seq post1");
        for (int i = 0; i < 4; i++) step(0,1,0,0, S_ARM,S_ARM, $sformatf("rst_seq arming%0d", i));
        for (int i = 0; i < 3; i++) step(0,1,0,0, S_ARD,S_ARD, $sformatf("rst_seq held%0d", i));
        for (int i = 0; i < 2; i++) step(0,0,0,0, S_ARD,S_ARD, $sformatf("rst_seq rel%0d", i));

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
